cpu_control: RTL and testbench
==============================

CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 The block SHALL provide the following parameters, one per line (name, default, meaning):
  OPCODE_WIDTH  5   instruction opcode field width
  COUNT_WIDTH   16  retired-instruction counter width
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high. Ports are as follows (name, direction, width, meaning):
  clock      in   1    rising-edge clock
  reset      in   1    asynchronous, active-high
  opcode     in   OPCODE_WIDTH   IR[15:11]; valid from DECODE onward
  z_flag     in   1    accumulator == 0
  n_flag     in   1    accumulator negative
  mem_ready  in   1    memory completes the current request this cycle
  mem_req    out  1    memory request
  mem_we     out  1    write strobe; qualified by mem_req
  addr_sel   out  1    0 = PC, 1 = sign-extended operand
  ir_en      out  1    load instruction register
  pc_en      out  1    update PC
  pc_sel     out  1    0 = PC+1, 1 = sign-extended operand
  acc_en     out  1    load accumulator
  acc_src    out  2    00 = ALU, 01 = memory data, 10 = extended immediate
  op_b_sel   out  1    ALU B operand: 0 = memory data, 1 = extended immediate
  alu_op     out  3    000 = pass, 001 = add, 010 = sub
  halted     out  1    core is stopped
  state_out  out  3    encoded FSM state
  instr_count out COUNT_WIDTH  retired instructions

Function
REQ-003 The FSM SHALL have the states FETCH=0, DECODE=1, MEM=2, EXECUTE=3 and HALT=4, output on state_out.
REQ-004 The opcodes SHALL be: 0 HLT, 1 STO, 2 LD, 3 LDI, 4 ADD, 5 ADDI, 6 SUB, 7 SUBI, 8 BEQ, 9 BNE, 10 BLT, 11 JMP; any other value is a NOP.
REQ-005 Outputs SHALL be combinational decodes of the state, opcode, flags and mem_ready; every output not named in a state SHALL be 0.
REQ-006 In FETCH: mem_req=1 and addr_sel=0. When mem_ready=1, ir_en=1, pc_en=1, pc_sel=0, and the next state is DECODE. Otherwise the FSM stays in FETCH with outputs unchanged.
REQ-007 DECODE SHALL drive no outputs and last one cycle. Transitions: HLT goes to HALT; STO, LD, ADD and SUB go to MEM; all others go to EXECUTE.
REQ-008 In MEM: mem_req=1 and addr_sel=1.
  STO: mem_we=1.
  LD: acc_src=01 and acc_en=mem_ready.
  ADD and SUB: acc_src=00, op_b_sel=0, alu_op=001 or 010, and acc_en=mem_ready.
  The FSM SHALL wait while mem_ready=0 and go to FETCH on mem_ready=1.
REQ-009 EXECUTE SHALL last one cycle and then go to FETCH.
  LDI: acc_en=1, acc_src=10.
  ADDI and SUBI: acc_en=1, acc_src=00, op_b_sel=1, alu_op=001 or 010.
  BEQ: pc_en=pc_sel=z_flag.
  BNE: pc_en=pc_sel=~z_flag.
  BLT: pc_en=pc_sel=n_flag.
  JMP: pc_en=pc_sel=1.
  NOP: no outputs.
REQ-010 HALT SHALL assert halted=1, drive all other outputs 0, and be left only by reset.
REQ-011 instr_count SHALL increment by 1 on the clock edge leaving MEM or EXECUTE, and on entry to HALT. It SHALL wrap from all-ones to 0.
REQ-012 With mem_ready constantly 1, every non-HLT instruction SHALL take exactly 3 cycles from FETCH to the next FETCH.
REQ-013 mem_ready asserted outside FETCH or MEM SHALL be ignored.
REQ-014 Flags SHALL be sampled only in the EXECUTE cycle.

Reset
REQ-015 While reset=1, the state SHALL be FETCH, instr_count SHALL be 0, and all outputs, including mem_req, SHALL be forced to 0 asynchronously.
REQ-016 After reset deasserts, the first rising edge SHALL find the FSM in FETCH with mem_req=1.
REQ-017 Reset asserted mid-FETCH or mid-MEM SHALL abort the transfer immediately, with no ir_en, acc_en or pc_en pulse.

Verification
REQ-018 Reset released, mem_ready=1, stream of LDI, ADDI, JMP -> state sequence 0,1,3,0,1,3,0,1,3; instr_count=3 after 9 cycles; pc_sel=1 only in the JMP EXECUTE cycle.
REQ-019 LD with mem_ready held low for 4 cycles in MEM -> mem_req=1 and addr_sel=1 stable for 5 cycles; acc_en=1 for exactly 1 cycle with acc_src=01.
REQ-020 BEQ with z_flag=0, then BEQ with z_flag=1 -> pc_en=0 in the first EXECUTE and pc_en=pc_sel=1 in the second; BNE gives the opposite results.
REQ-021 HLT -> state_out=4 and halted=1 after DECODE; instr_count increments once; 20 further cycles with mem_ready toggling cause no output change; reset returns the FSM to FETCH with count 0.
REQ-022 Preload instr_count to 0xFFFF by running 65535 NOPs, then one more NOP -> instr_count=0x0000.
REQ-023 Reset asserted asynchronously between clock edges during STO in MEM -> mem_we and mem_req fall before the next edge; state_out=0.

Source files
------------

// File: rtl/cpu_control.sv
// cpu_control: multi-cycle control unit for a small accumulator CPU.
//
// Each instruction walks FETCH -> DECODE -> (MEM | EXECUTE) -> FETCH; HLT parks the
// core in HALT until reset. Datapath controls are pure combinational decodes of the
// current state, opcode, flags and mem_ready.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   opcode              IR[15:11], valid from DECODE onward
//   z_flag, n_flag      accumulator zero / negative, looked at only in EXECUTE
//   mem_ready           memory completes the current request this cycle
//   mem_req, mem_we     memory request and write strobe
//   addr_sel            memory address: 0 = PC, 1 = sign-extended operand
//   ir_en               load instruction register
//   pc_en, pc_sel       update PC; 0 = PC+1, 1 = sign-extended operand
//   acc_en, acc_src     load accumulator; 00 = ALU, 01 = memory, 10 = immediate
//   op_b_sel, alu_op    ALU B operand (0 = memory, 1 = immediate); 000 pass/001 add/010 sub
//   halted              core is stopped
//   state_out           encoded FSM state
//   instr_count         retired-instruction counter, wraps
module cpu_control #(
  parameter int unsigned OPCODE_WIDTH = 5,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    z_flag,
  input  logic                    n_flag,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    addr_sel,
  output logic                    ir_en,
  output logic                    pc_en,
  output logic                    pc_sel,
  output logic                    acc_en,
  output logic [1:0]              acc_src,
  output logic                    op_b_sel,
  output logic [2:0]              alu_op,
  output logic                    halted,
  output logic [2:0]              state_out,
  output logic [COUNT_WIDTH-1:0]  instr_count
);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StMem     = 3'd2,
    StExecute = 3'd3,
    StHalt    = 3'd4
  } state_e;

  localparam logic [OPCODE_WIDTH-1:0] OpHlt  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OpSto  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OpLd   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OpLdi  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OpAdd  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OpAddi = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OpSub  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OpSubi = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OpBeq  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OpBne  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OpBlt  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OpJmp  = OPCODE_WIDTH'(11);

  localparam logic [1:0] SrcAlu = 2'b00;
  localparam logic [1:0] SrcMem = 2'b01;
  localparam logic [1:0] SrcImm = 2'b10;

  localparam logic [2:0] AluAdd = 3'b001;
  localparam logic [2:0] AluSub = 3'b010;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   is_mem_op;
  logic                   retire;

  // Opcodes that need a data-memory access go through MEM; everything else but
  // HLT (including unknown opcodes, treated as NOP) goes through EXECUTE.
  assign is_mem_op = (opcode == OpSto) || (opcode == OpLd) ||
                     (opcode == OpAdd) || (opcode == OpSub);

  // Retirement happens on the edge leaving MEM/EXECUTE, or entering HALT.
  assign retire = ((state_q == StMem) && mem_ready) ||
                  (state_q == StExecute) ||
                  ((state_q == StDecode) && (opcode == OpHlt));

  // State register and retired-instruction counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (retire) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (opcode == OpHlt) begin
          state_d = StHalt;
        end else if (is_mem_op) begin
          state_d = StMem;
        end else begin
          state_d = StExecute;
        end
      end
      StMem: begin
        if (mem_ready) begin
          state_d = StFetch;
        end
      end
      StExecute: state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StFetch;
    endcase
  end

  // Output decode. Reset gates everything so an in-flight transfer is dropped
  // immediately, without waiting for the state register to settle.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = 1'b0;
    acc_en   = 1'b0;
    acc_src  = SrcAlu;
    op_b_sel = 1'b0;
    alu_op   = 3'b000;
    halted   = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_en = 1'b1;
            pc_en = 1'b1;
          end
        end
        StMem: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          if (opcode == OpSto) begin
            mem_we = 1'b1;
          end else if (opcode == OpLd) begin
            acc_src = SrcMem;
            acc_en  = mem_ready;
          end else if (opcode == OpAdd) begin
            alu_op = AluAdd;
            acc_en = mem_ready;
          end else if (opcode == OpSub) begin
            alu_op = AluSub;
            acc_en = mem_ready;
          end
        end
        StExecute: begin
          if (opcode == OpLdi) begin
            acc_en  = 1'b1;
            acc_src = SrcImm;
          end else if (opcode == OpAddi) begin
            acc_en   = 1'b1;
            op_b_sel = 1'b1;
            alu_op   = AluAdd;
          end else if (opcode == OpSubi) begin
            acc_en   = 1'b1;
            op_b_sel = 1'b1;
            alu_op   = AluSub;
          end else if (opcode == OpBeq) begin
            pc_en  = z_flag;
            pc_sel = z_flag;
          end else if (opcode == OpBne) begin
            pc_en  = ~z_flag;
            pc_sel = ~z_flag;
          end else if (opcode == OpBlt) begin
            pc_en  = n_flag;
            pc_sel = n_flag;
          end else if (opcode == OpJmp) begin
            pc_en  = 1'b1;
            pc_sel = 1'b1;
          end
        end
        StHalt: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_out   = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control. Expected state/outputs/count for every observed
// point are pushed to a scoreboard queue and popped when the DUT is sampled.
// A second instance with an 8-bit counter lets the wrap-around be reached quickly.
module tb_cpu_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] opcode;
  logic       z_flag, n_flag, mem_ready;

  logic        mem_req, mem_we, addr_sel, ir_en, pc_en, pc_sel, acc_en, op_b_sel, halted;
  logic [1:0]  acc_src;
  logic [2:0]  alu_op, state_out;
  logic [15:0] instr_count;

  logic       w_mem_req, w_mem_we, w_addr_sel, w_ir_en, w_pc_en, w_pc_sel, w_acc_en;
  logic       w_op_b_sel, w_halted;
  logic [1:0] w_acc_src;
  logic [2:0] w_alu_op, w_state_out;
  logic [7:0] w_instr_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [13:0] o;
    int          cnt;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  cpu_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .z_flag(z_flag), .n_flag(n_flag),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .acc_en(acc_en), .acc_src(acc_src),
    .op_b_sel(op_b_sel), .alu_op(alu_op), .halted(halted), .state_out(state_out),
    .instr_count(instr_count)
  );

  cpu_control #(.OPCODE_WIDTH(5), .COUNT_WIDTH(8)) dut_w (
    .clock(clock), .reset(reset), .opcode(opcode), .z_flag(z_flag), .n_flag(n_flag),
    .mem_ready(mem_ready), .mem_req(w_mem_req), .mem_we(w_mem_we), .addr_sel(w_addr_sel),
    .ir_en(w_ir_en), .pc_en(w_pc_en), .pc_sel(w_pc_sel), .acc_en(w_acc_en),
    .acc_src(w_acc_src), .op_b_sel(w_op_b_sel), .alu_op(w_alu_op), .halted(w_halted),
    .state_out(w_state_out), .instr_count(w_instr_count)
  );

  logic [13:0] obs, obs_w;
  assign obs   = {mem_req, mem_we, addr_sel, ir_en, pc_en, pc_sel, acc_en, acc_src,
                  op_b_sel, alu_op, halted};
  assign obs_w = {w_mem_req, w_mem_we, w_addr_sel, w_ir_en, w_pc_en, w_pc_sel, w_acc_en,
                  w_acc_src, w_op_b_sel, w_alu_op, w_halted};

  function automatic logic [13:0] pk(input logic mreq, input logic we, input logic asel,
                                     input logic ir, input logic pce, input logic pcs,
                                     input logic acce, input logic [1:0] src,
                                     input logic obsel, input logic [2:0] alu,
                                     input logic hlt);
    return {mreq, we, asel, ir, pce, pcs, acce, src, obsel, alu, hlt};
  endfunction

  // Push the expectation, then pop and compare against the DUT right now.
  task automatic check_now(input string tag, input logic [2:0] st, input logic [13:0] o);
    exp_t e;
    sb.push_back('{tag: tag, st: st, o: o, cnt: exp_cnt});
    e = sb.pop_front();
    checks += 5;
    assert (state_out === e.st) else begin
      errors++;
      $error("FAIL %s state got %0d want %0d", e.tag, state_out, e.st);
    end
    assert (obs === e.o) else begin
      errors++;
      $error("FAIL %s outputs got %b want %b", e.tag, obs, e.o);
    end
    assert (instr_count === 16'(e.cnt)) else begin
      errors++;
      $error("FAIL %s count got %0h want %0h", e.tag, instr_count, 16'(e.cnt));
    end
    assert (obs_w === e.o && w_state_out === e.st) else begin
      errors++;
      $error("FAIL %s narrow outputs got %b/%0d want %b/%0d", e.tag, obs_w, w_state_out,
             e.o, e.st);
    end
    assert (w_instr_count === 8'(e.cnt)) else begin
      errors++;
      $error("FAIL %s narrow count got %0h want %0h", e.tag, w_instr_count, 8'(e.cnt));
    end
  endtask

  // Inputs are already driven (at posedge+1); sample on the falling edge.
  task automatic step(input string tag, input logic [2:0] st, input logic [13:0] o);
    @(negedge clock);
    check_now(tag, st, o);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_ok(input string tag);
    mem_ready = 1'b1;
    step({tag, "_fetch"}, 3'd0, pk(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 3'b000, 0));
  endtask

  task automatic decode(input string tag, input logic [4:0] op);
    opcode    = op;
    mem_ready = 1'b1;  // ignored in DECODE
    step({tag, "_decode"}, 3'd1, '0);
  endtask

  task automatic instr_exec(input string tag, input logic [4:0] op, input logic z,
                            input logic n, input logic [13:0] exec_o);
    fetch_ok(tag);
    decode(tag, op);
    z_flag    = z;
    n_flag    = n;
    mem_ready = 1'b1;
    step({tag, "_exec"}, 3'd3, exec_o);
    exp_cnt++;
  endtask

  task automatic instr_mem(input string tag, input logic [4:0] op, input int waits,
                           input logic [13:0] wait_o, input logic [13:0] done_o);
    fetch_ok(tag);
    decode(tag, op);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      step({tag, "_memwait"}, 3'd2, wait_o);
    end
    mem_ready = 1'b1;
    step({tag, "_memdone"}, 3'd2, done_o);
    exp_cnt++;
  endtask

  task automatic do_reset(input string tag);
    reset   = 1'b1;
    exp_cnt = 0;
    #1;
    check_now({tag, "_in_reset"}, 3'd0, '0);
    @(posedge clock);
    #1;
    check_now({tag, "_held"}, 3'd0, '0);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 5'd12;
    z_flag    = 1'b0;
    n_flag    = 1'b0;
    mem_ready = 1'b1;
    #3;
    check_now("por", 3'd0, '0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // LDI, ADDI, JMP back-to-back with memory always ready.
    instr_exec("ldi", 5'd3, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 3'b000, 0));
    instr_exec("addi", 5'd5, 1'b1, 1'b1, pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 1, 3'b001, 0));
    instr_exec("jmp", 5'd11, 1'b0, 1'b0, pk(0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 3'b000, 0));
    instr_exec("subi", 5'd7, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 1, 3'b010, 0));

    // Fetch stall, then LD with four wait cycles.
    mem_ready = 1'b0;
    step("fetch_stall", 3'd0, pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 0));
    instr_mem("ld", 5'd2, 4, pk(1, 0, 1, 0, 0, 0, 0, 2'b01, 0, 3'b000, 0),
              pk(1, 0, 1, 0, 0, 0, 1, 2'b01, 0, 3'b000, 0));
    instr_mem("add", 5'd4, 0, '0, pk(1, 0, 1, 0, 0, 0, 1, 2'b00, 0, 3'b001, 0));
    instr_mem("sub", 5'd6, 1, pk(1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 3'b010, 0),
              pk(1, 0, 1, 0, 0, 0, 1, 2'b00, 0, 3'b010, 0));
    instr_mem("sto", 5'd1, 1, pk(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 3'b000, 0),
              pk(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 3'b000, 0));

    // Conditional branches.
    instr_exec("beq_nz", 5'd8, 1'b0, 1'b1, '0);
    instr_exec("beq_z", 5'd8, 1'b1, 1'b0, pk(0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 3'b000, 0));
    instr_exec("bne_nz", 5'd9, 1'b0, 1'b0, pk(0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 3'b000, 0));
    instr_exec("bne_z", 5'd9, 1'b1, 1'b1, '0);
    instr_exec("blt_n", 5'd10, 1'b0, 1'b1, pk(0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 3'b000, 0));
    instr_exec("blt_p", 5'd10, 1'b1, 1'b0, '0);
    instr_exec("nop", 5'd31, 1'b1, 1'b1, '0);

    // Reset mid-FETCH with mem_ready high: the ir_en/pc_en pulse must vanish.
    mem_ready = 1'b1;
    #2;
    check_now("fetch_pre_abort", 3'd0, pk(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 3'b000, 0));
    do_reset("fetch_abort");

    // Reset between edges while STO is waiting in MEM.
    fetch_ok("sto_abort");
    decode("sto_abort", 5'd1);
    mem_ready = 1'b0;
    #2;
    check_now("sto_pre_abort", 3'd2, pk(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 3'b000, 0));
    do_reset("sto_abort");
    mem_ready = 1'b0;
    step("post_reset_fetch", 3'd0, pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 0));

    // HLT: count bumps on entry, then nothing moves until reset.
    fetch_ok("hlt");
    decode("hlt", 5'd0);
    exp_cnt++;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      z_flag    = i[1];
      opcode    = 5'(i);
      step("halt_hold", 3'd4, pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 1));
    end
    do_reset("halt_exit");

    // Counter wrap on the 8-bit instance: 255 NOPs reach all-ones, one more wraps.
    for (int i = 0; i < 255; i++) begin
      instr_exec("wrap_nop", 5'd12, 1'b0, 1'b0, '0);
    end
    mem_ready = 1'b0;
    step("wrap_full", 3'd0, pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 0));
    instr_exec("wrap_last", 5'd15, 1'b0, 1'b0, '0);
    mem_ready = 1'b0;
    step("wrap_zero", 3'd0, pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
